inst_decode_stage: RTL and testbench
====================================

// Module: inst_decode_stage
// PURPOSE
//  Registered, parametrised MIPS decode stage between fetch and register-read. It splits each
//  32-bit instruction into fields, extends the immediate and classifies the format (R/I/J).
//  It also picks the destination register. A 2-entry elastic buffer with valid/ready on both
//  sides absorbs back-pressure.
// PARAMETERS
//  XLEN     32  width of extended immediate (imm_ext); >=16
//  PC_W     32  width of PC tag carried alongside each instruction
//  DEPTH    2   buffer entries; legal values 1 (no skid, bubble on stall) or 2 (full throughput)
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       reset; one clock; reset is asynchronous and active-high
//  flush       in   1       synchronous discard of all buffered entries
//  in_valid    in   1       upstream instruction valid
//  in_ready    out  1       stage can accept this cycle
//  in_inst     in   32      instruction word
//  in_pc       in   PC_W    PC of instruction
//  out_valid   out  1       decoded entry at head valid
//  out_ready   in   1       downstream accepts head
//  out_op      out  6       inst[31:26]
//  out_rs      out  5       inst[25:21]
//  out_rt      out  5       inst[20:16]
//  out_rd      out  5       inst[15:11]
//  out_shamt   out  5       inst[10:6]
//  out_func    out  6       inst[5:0]
//  out_imm_ext out  XLEN    inst[15:0] extended (rules below)
//  out_j_addr  out  26      inst[25:0]
//  out_class   out  2       0=R, 1=I, 2=J, 3 unused
//  out_dst     out  5       destination register number
//  out_pc      out  PC_W    PC tag of head entry
//  out_illegal out  1       opcode unsupported (see CONFIGURATION)
// BEHAVIOUR
//  - Decode is combinational on in_inst. Each entry stores the decoded record, not the raw word.
//  - Push when in_valid&&in_ready. Pop when out_valid&&out_ready. Latency in->out is 1 cycle;
//    no same-cycle bypass.
//  - count 0..DEPTH; in_ready = (count<DEPTH) || pop (DEPTH=2 only; DEPTH=1: in_ready=(count==0)).
//  - Simultaneous push+pop at count==DEPTH: allowed for DEPTH=2, count unchanged, order kept.
//  - FIFO order strict. Head holds stable while out_valid && !out_ready.
//  - flush: next cycle count=0, out_valid=0. A push in the flush cycle is dropped. flush wins
//    over push and pop.
//  - class: op==0 -> R; op==2 (J) or 3 (JAL) -> J; otherwise I.
//  - imm_ext: zero-extend for op 0x0C ANDI, 0x0D ORI, 0x0E XORI; otherwise sign-extend
//    inst[15] to XLEN.
//  - dst: R -> rd; JAL -> 5'd31; I -> rt; J (non-JAL) -> 0. Stores/branches still report rt;
//    downstream qualifies write-enable.
//  - Reset (any time, incl. mid-transfer): count=0, out_valid=0, in_ready=1 after release.
//    All out_* data = 0, out_class=0, out_illegal=0.
// CONFIGURATION
//  DECODE_ILLEGAL_TRAP_EN defined:
//    out_illegal=1 when op is not in the supported set
//    {0,2,3,4,5,6,7,8,9,0x0A,0x0B,0x0C,0x0D,0x0E,0x0F,0x20,0x23,0x24,0x25,0x28,0x2B}.
//    Also 1 when op==0 and func is not in the R-type table of mips_decode_pkg. The flag travels
//    with its entry.
//  DECODE_ILLEGAL_TRAP_EN undefined: port present, constant 0, no table logic synthesised.
// STRUCTURE
//  mips_decode_pkg:
//    opcode/func localparams, class encoding (CLS_R/I/J), REG_RA=31,
//    decoded-record width constant, supported-opcode/func tables
//  sub-module inst_skid_buffer: generic DEPTH-entry valid/ready buffer with flush (width param).
//  Top holds decode logic + one inst_skid_buffer instance.
// TESTING
//  1 Reset: assert rst mid-stream with count=2 -> out_valid=0, in_ready=1, all outputs 0 next edge.
//  2 ADDI 0x2008FFFF, out_ready=1 -> 1 cycle later:
//    class=1, rt=8, dst=8, imm_ext=0xFFFFFFFF.
//  3 ORI 0x3508FFFF -> imm_ext=0x0000FFFF.
//    R-type ADD 0x01095020 -> class=0, dst=10, func=0x20.
//  4 JAL 0x0C000040 -> class=2, j_addr=0x40, dst=31.
//    J 0x08000040 -> dst=0.
//  5 Stall: out_ready=0, push 3 instrs -> 2 accepted, in_ready=0 on 3rd.
//    out_ready=1 -> drained in order, 1/cycle, and push+pop at full keeps throughput.
//  6 flush with count=2 and in_valid=1 -> next cycle out_valid=0, pushed word absent.
//    With _EN: op 0x3F -> out_illegal=1.

Source files
------------

// File: rtl/mips_decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_decode_pkg
//  Description : Shared constants for the MIPS decode stage: opcode and
//                function-code values, instruction class encoding, the
//                link register number, decoded-record width, and the
//                supported-opcode / R-type function tables used by the
//                optional illegal-instruction trap (DECODE_ILLEGAL_TRAP_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_decode_pkg;

    // Primary opcodes (inst[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Instruction class encoding carried on out_class
    typedef enum logic [1:0] {
        CLS_R = 2'd0,
        CLS_I = 2'd1,
        CLS_J = 2'd2
    } inst_class_e;

    localparam logic [4:0] REG_RA   = 5'd31;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // op6 + rs5 + rt5 + rd5 + shamt5 + func6 + j_addr26 + class2 + dst5 + illegal1
    localparam int REC_FIXED_W = 66;

    function automatic int rec_width(input int xlen, input int pc_w);
        return REC_FIXED_W + xlen + pc_w;
    endfunction

    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
            OP_LUI, OP_LB, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SW:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

    // R-type function codes (inst[5:0] when op == 0)
    function automatic logic func_supported(input logic [5:0] func);
        case (func)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,   // shifts
            6'h08, 6'h09,                               // JR, JALR
            6'h10, 6'h11, 6'h12, 6'h13,                 // MFHI..MTLO
            6'h18, 6'h19, 6'h1A, 6'h1B,                 // MULT..DIVU
            6'h20, 6'h21, 6'h22, 6'h23,                 // ADD..SUBU
            6'h24, 6'h25, 6'h26, 6'h27,                 // AND..NOR
            6'h2A, 6'h2B:                               // SLT, SLTU
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_decode_stage_if
//  Description : Handshake and data bundle of the decode stage.
//                master : fetch side / downstream consumer (drives flush,
//                         in_valid, in_inst, in_pc, out_ready)
//                slave  : the decode stage itself
//  Parameters  : XLEN (extended immediate width), PC_W (PC tag width)
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_decode_stage_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [5:0]      out_op;
    logic [4:0]      out_rs;
    logic [4:0]      out_rt;
    logic [4:0]      out_rd;
    logic [4:0]      out_shamt;
    logic [5:0]      out_func;
    logic [XLEN-1:0] out_imm_ext;
    logic [25:0]     out_j_addr;
    logic [1:0]      out_class;
    logic [4:0]      out_dst;
    logic [PC_W-1:0] out_pc;
    logic            out_illegal;

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_op, out_rs, out_rt, out_rd, out_shamt,
               out_func, out_imm_ext, out_j_addr, out_class, out_dst, out_pc,
               out_illegal
    );

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_op, out_rs, out_rt, out_rd, out_shamt,
               out_func, out_imm_ext, out_j_addr, out_class, out_dst, out_pc,
               out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/inst_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : inst_skid_buffer
//  Description : Generic DEPTH-entry valid/ready FIFO buffer with synchronous
//                flush and asynchronous active-high reset. DEPTH=2 gives full
//                throughput (push allowed while full if the head pops);
//                DEPTH=1 accepts only when empty.
//  Ports       : clk, rst, flush
//                in_valid / in_ready / in_data   - upstream side
//                out_valid / out_ready / out_data - downstream side (head)
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_skid_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             flush,
    input  wire logic             in_valid,
    output      logic             in_ready,
    input  wire logic [WIDTH-1:0] in_data,
    output      logic             out_valid,
    input  wire logic             out_ready,
    output      logic [WIDTH-1:0] out_data
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == C_LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rd_ptr];
    assign w_pop     = out_valid && out_ready;
    assign w_push    = in_valid && in_ready;

    generate
        if (DEPTH == 1) begin : g_ready_single
            assign in_ready = (r_count == '0);
        end else begin : g_ready_skid
            // A slot frees up this cycle if the head is leaving.
            assign in_ready = (r_count < C_DEPTH) || w_pop;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/inst_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : inst_decode_stage
//  Description : Registered MIPS decode stage. Splits each instruction into
//                its fields, extends the immediate, classifies the format
//                (R/I/J), picks the destination register and queues the
//                decoded record in a DEPTH-entry elastic buffer.
//  Parameters  : XLEN (>=16) immediate width, PC_W PC tag width,
//                DEPTH 1 or 2 buffer entries
//  Ports       : clk, rst (async, active-high)
//                bus (inst_decode_stage_if.slave): flush, in_* handshake and
//                instruction/PC, out_* handshake and decoded fields
//  Macro       : DECODE_ILLEGAL_TRAP_EN - when defined, out_illegal flags
//                unsupported opcodes and unsupported R-type function codes;
//                otherwise out_illegal is constant 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_decode_stage
    import mips_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int DEPTH = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    inst_decode_stage_if.slave  bus
);
    localparam int REC_W = rec_width(XLEN, PC_W);

    logic [5:0]      w_op;
    logic [4:0]      w_rs;
    logic [4:0]      w_rt;
    logic [4:0]      w_rd;
    logic [4:0]      w_shamt;
    logic [5:0]      w_func;
    logic [15:0]     w_imm;
    logic [25:0]     w_j_addr;
    logic [1:0]      w_class;
    logic [4:0]      w_dst;
    logic [XLEN-1:0] w_imm_ext;
    logic            w_illegal;
    logic [REC_W-1:0] w_rec_in;
    logic [REC_W-1:0] w_rec_out;

    assign w_op     = bus.in_inst[31:26];
    assign w_rs     = bus.in_inst[25:21];
    assign w_rt     = bus.in_inst[20:16];
    assign w_rd     = bus.in_inst[15:11];
    assign w_shamt  = bus.in_inst[10:6];
    assign w_func   = bus.in_inst[5:0];
    assign w_imm    = bus.in_inst[15:0];
    assign w_j_addr = bus.in_inst[25:0];

    always_comb begin
        w_class = CLS_I;
        if (w_op == OP_RTYPE) begin
            w_class = CLS_R;
        end else if ((w_op == OP_J) || (w_op == OP_JAL)) begin
            w_class = CLS_J;
        end
    end

    // Logical immediates are zero-extended; everything else sign-extends.
    // Size casts keep this legal for XLEN == 16.
    always_comb begin
        if ((w_op == OP_ANDI) || (w_op == OP_ORI) || (w_op == OP_XORI)) begin
            w_imm_ext = XLEN'(w_imm);
        end else begin
            w_imm_ext = XLEN'($signed(w_imm));
        end
    end

    // Stores and branches still report rt; write-enable is qualified later.
    always_comb begin
        w_dst = w_rt;
        if (w_op == OP_RTYPE) begin
            w_dst = w_rd;
        end else if (w_op == OP_JAL) begin
            w_dst = REG_RA;
        end else if (w_op == OP_J) begin
            w_dst = REG_ZERO;
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign w_illegal = !op_supported(w_op) ||
                       ((w_op == OP_RTYPE) && !func_supported(w_func));
`else
    assign w_illegal = 1'b0;
`endif

    assign w_rec_in = {w_op, w_rs, w_rt, w_rd, w_shamt, w_func, w_j_addr,
                       w_class, w_dst, w_illegal, w_imm_ext, bus.in_pc};

    inst_skid_buffer #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (w_rec_in),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (w_rec_out)
    );

    assign {bus.out_op, bus.out_rs, bus.out_rt, bus.out_rd, bus.out_shamt,
            bus.out_func, bus.out_j_addr, bus.out_class, bus.out_dst,
            bus.out_illegal, bus.out_imm_ext, bus.out_pc} = w_rec_out;
endmodule
`default_nettype wire

// File: tb/tb_inst_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_decode_stage
//  Description : Self-checking bench for inst_decode_stage: a table of known
//                instructions with hand-derived decode results, hand-written
//                stall / flush / reset sequences, and randomized traffic
//                compared against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_decode_stage;
    localparam int XLEN = 32;
    localparam int PC_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_decode_stage_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

    inst_decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic seen_ready;
    logic seen_valid;
    logic [31:0] mq_inst[$];
    logic [31:0] mq_pc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  cls;
        logic [4:0]  dst;
        logic [31:0] imm;
        logic        ill;
    } ref_t;

    // Reference decode computed directly from the instruction-set rules.
    function automatic ref_t ref_decode(input logic [31:0] inst);
        ref_t r;
        int unsigned op = inst >> 26;
        int unsigned lo = inst & 32'hFFFF;
        int unsigned fn = inst & 32'h3F;
        if (op == 0) r.cls = 2'd0;
        else if (op == 2 || op == 3) r.cls = 2'd2;
        else r.cls = 2'd1;
        if (op == 12 || op == 13 || op == 14) r.imm = lo;
        else if (lo >= 32768) r.imm = lo | 32'hFFFF0000;
        else r.imm = lo;
        if (op == 3) r.dst = 5'd31;
        else if (r.cls == 2'd0) r.dst = 5'((inst >> 11) & 32'h1F);
        else if (r.cls == 2'd2) r.dst = 5'd0;
        else r.dst = 5'((inst >> 16) & 32'h1F);
`ifdef DECODE_ILLEGAL_TRAP_EN
        r.ill = !(op inside {0,2,3,4,5,6,7,8,9,10,11,12,13,14,15,32,35,36,37,40,43}) ||
                (op == 0 && !(fn inside {0,2,3,4,6,7,8,9,16,17,18,19,24,25,26,27,
                                         32,33,34,35,36,37,38,39,42,43}));
`else
        r.ill = 1'b0;
        if (fn > 63) r.ill = 1'b1;
`endif
        return r;
    endfunction

    task automatic check_head(input logic [31:0] inst, input logic [31:0] pc);
        ref_t r = ref_decode(inst);
        chk("op",      bus.out_op,      inst >> 26);
        chk("rs",      bus.out_rs,      (inst >> 21) & 32'h1F);
        chk("rt",      bus.out_rt,      (inst >> 16) & 32'h1F);
        chk("rd",      bus.out_rd,      (inst >> 11) & 32'h1F);
        chk("shamt",   bus.out_shamt,   (inst >> 6) & 32'h1F);
        chk("func",    bus.out_func,    inst & 32'h3F);
        chk("j_addr",  bus.out_j_addr,  inst & 32'h03FFFFFF);
        chk("imm_ext", bus.out_imm_ext, r.imm);
        chk("class",   bus.out_class,   r.cls);
        chk("dst",     bus.out_dst,     r.dst);
        chk("pc",      bus.out_pc,      pc);
        chk("illegal", bus.out_illegal, r.ill);
    endtask

    // One clock of traffic, entered and left at posedge+1.
    task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        logic exp_ready, push, pop;
        int sz;
        bus.in_valid  = v;
        bus.in_inst   = inst;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        bus.flush     = fl;
        @(negedge clk);
        sz = mq_inst.size();
        exp_ready = (sz < 2) || ordy;
        seen_ready = bus.in_ready;
        seen_valid = bus.out_valid;
        chk("in_ready", bus.in_ready, exp_ready);
        chk("out_valid", bus.out_valid, sz != 0);
        if (sz != 0) check_head(mq_inst[0], mq_pc[0]);
        push = v && exp_ready;
        pop  = (sz != 0) && ordy;
        @(posedge clk);
        #1;
        if (fl) begin
            mq_inst.delete();
            mq_pc.delete();
        end else begin
            if (pop) begin
                void'(mq_inst.pop_front());
                void'(mq_pc.pop_front());
            end
            if (push) begin
                mq_inst.push_back(inst);
                mq_pc.push_back(pc);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, bus.out_valid, 1'b0);
        chk({tag, "_ready"}, bus.in_ready, 1'b1);
        chk({tag, "_data"},
            {bus.out_op, bus.out_rs, bus.out_rt, bus.out_rd, bus.out_shamt, bus.out_func,
             bus.out_j_addr, bus.out_dst}, 64'd0);
        chk({tag, "_imm"}, bus.out_imm_ext, 0);
        chk({tag, "_pc"}, bus.out_pc, 0);
        chk({tag, "_class"}, bus.out_class, 0);
        chk({tag, "_illegal"}, bus.out_illegal, 0);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [5:0] ops [12] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h0C,
                                 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
        logic [5:0] op;
        logic [25:0] rest;
        if ($urandom_range(0, 9) < 8) op = ops[$urandom_range(0, 11)];
        else op = 6'($urandom_range(0, 63));
        rest = 26'($urandom);
        return {op, rest};
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic [5:0]  op;
        logic [4:0]  rt;
        logic [5:0]  func;
        logic [1:0]  cls;
        logic [4:0]  dst;
        logic [31:0] imm;
        logic [25:0] jaddr;
    } vec_t;

    vec_t vt [10];

    initial begin
        vt[0] = '{32'h2008FFFF, 6'h08, 5'd8,  6'h3F, 2'd1, 5'd8,  32'hFFFFFFFF, 26'h008FFFF}; // ADDI
        vt[1] = '{32'h3508FFFF, 6'h0D, 5'd8,  6'h3F, 2'd1, 5'd8,  32'h0000FFFF, 26'h108FFFF}; // ORI
        vt[2] = '{32'h01095020, 6'h00, 5'd9,  6'h20, 2'd0, 5'd10, 32'h00005020, 26'h1095020}; // ADD
        vt[3] = '{32'h0C000040, 6'h03, 5'd0,  6'h00, 2'd2, 5'd31, 32'h00000040, 26'h0000040}; // JAL
        vt[4] = '{32'h08000040, 6'h02, 5'd0,  6'h00, 2'd2, 5'd0,  32'h00000040, 26'h0000040}; // J
        vt[5] = '{32'h3A2A8001, 6'h0E, 5'd10, 6'h01, 2'd1, 5'd10, 32'h00008001, 26'h22A8001}; // XORI
        vt[6] = '{32'h8C48FFFC, 6'h23, 5'd8,  6'h3C, 2'd1, 5'd8,  32'hFFFFFFFC, 26'h048FFFC}; // LW
        vt[7] = '{32'h1109FFFE, 6'h04, 5'd9,  6'h3E, 2'd1, 5'd9,  32'hFFFFFFFE, 26'h109FFFE}; // BEQ
        vt[8] = '{32'h31088000, 6'h0C, 5'd8,  6'h00, 2'd1, 5'd8,  32'h00008000, 26'h1088000}; // ANDI
        vt[9] = '{32'hAFA80010, 6'h2B, 5'd8,  6'h10, 2'd1, 5'd8,  32'h00000010, 26'h3A80010}; // SW

        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_inst = '0;
        bus.in_pc = '0;   bus.out_ready = 1'b0;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check_zero("por_in_reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_zero("por_release");

        // Table: push each vector; it is the head one edge later.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, vt[i].inst, 32'h1000 + 32'(4 * i), 1'b1, 1'b0);
            chk("tbl_valid", bus.out_valid, 1'b1);
            chk("tbl_op",    bus.out_op,    vt[i].op);
            chk("tbl_rt",    bus.out_rt,    vt[i].rt);
            chk("tbl_func",  bus.out_func,  vt[i].func);
            chk("tbl_class", bus.out_class, vt[i].cls);
            chk("tbl_dst",   bus.out_dst,   vt[i].dst);
            chk("tbl_imm",   bus.out_imm_ext, vt[i].imm);
            chk("tbl_jaddr", bus.out_j_addr, vt[i].jaddr);
            chk("tbl_pc",    bus.out_pc,    32'h1000 + 32'(4 * i));
            chk("tbl_illegal", bus.out_illegal, 1'b0);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Stall: only two of three pushes accepted, then push+pop at full.
        cycle(1'b1, 32'h2001_0001, 32'h2000, 1'b0, 1'b0);
        cycle(1'b1, 32'h2002_0002, 32'h2004, 1'b0, 1'b0);
        cycle(1'b1, 32'h2003_0003, 32'h2008, 1'b0, 1'b0);
        chk("stall_third_ready", seen_ready, 1'b0);
        cycle(1'b1, 32'h2003_0003, 32'h2008, 1'b1, 1'b0);
        chk("full_pushpop_ready", seen_ready, 1'b1);
        cycle(1'b1, 32'h2004_0004, 32'h200C, 1'b1, 1'b0);
        chk("full_pushpop_ready2", seen_ready, 1'b1);
        repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with two entries and a concurrent push.
        cycle(1'b1, 32'h2005_0005, 32'h3000, 1'b0, 1'b0);
        cycle(1'b1, 32'h2006_0006, 32'h3004, 1'b0, 1'b0);
        cycle(1'b1, 32'h2007_0007, 32'h3008, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("flush_empty", seen_valid, 1'b0);

        // Asynchronous reset mid-stream with two entries buffered.
        cycle(1'b1, 32'h2408_1234, 32'h4000, 1'b0, 1'b0);
        cycle(1'b1, 32'h2409_5678, 32'h4004, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #2;
        check_zero("rst_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq_inst.delete();
        mq_pc.delete();
        check_zero("rst_release");
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

`ifdef DECODE_ILLEGAL_TRAP_EN
        cycle(1'b1, 32'hFC00_0000, 32'h5000, 1'b1, 1'b0);
        chk("illegal_op3f", bus.out_illegal, 1'b1);
        cycle(1'b1, 32'h0000_0001, 32'h5004, 1'b1, 1'b0);
        chk("illegal_func01", bus.out_illegal, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`endif

        // Randomized traffic against the queue model.
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 3) != 0, rand_inst(), $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
        end
        repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
